// File: rtl/deplasare_pkg.sv
// Shared constants and helpers for the perimeter segment animator.
// Maps a perimeter position to a display index and a segment index.
package deplasare_pkg;

    localparam logic [2:0] SEG_A  = 3'd0;
    localparam logic [2:0] SEG_B  = 3'd1;
    localparam logic [2:0] SEG_C  = 3'd2;
    localparam logic [2:0] SEG_D  = 3'd3;
    localparam logic [2:0] SEG_E  = 3'd4;
    localparam logic [2:0] SEG_F  = 3'd5;
    localparam logic [2:0] SEG_G  = 3'd6;
    localparam logic [2:0] SEG_DP = 3'd7;

    typedef struct packed {
        int         disp;
        logic [2:0] seg;
    } seg_loc_t;

    function automatic logic [7:0] seg_off(input logic common_anode);
        return common_anode ? 8'hFF : 8'h00;
    endfunction

    // Clockwise walk: top row left to right, right edge down, bottom row
    // right to left, then up the left edge.
    function automatic seg_loc_t pos_to_seg(input int pos, input int n);
        seg_loc_t loc;
        if (pos < n) begin
            loc.disp = n - 1 - pos;
            loc.seg  = SEG_A;
        end else if (pos == n) begin
            loc.disp = 0;
            loc.seg  = SEG_B;
        end else if (pos == n + 1) begin
            loc.disp = 0;
            loc.seg  = SEG_C;
        end else if (pos < 2 * n + 2) begin
            loc.disp = pos - n - 2;
            loc.seg  = SEG_D;
        end else if (pos == 2 * n + 2) begin
            loc.disp = n - 1;
            loc.seg  = SEG_E;
        end else begin
            loc.disp = n - 1;
            loc.seg  = SEG_F;
        end
        return loc;
    endfunction

endpackage

// File: rtl/deplasare_prescaler.sv
// Step-rate prescaler: pulses tick_o once every STEP_CYCLES enabled cycles.
// Holding en_i low freezes the count; clear_i discards it.
module deplasare_prescaler #(
    parameter int STEP_CYCLES = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/deplasare_cerc_hex.sv
// Moves a lit segment (or a trail of them) around the outer perimeter of a
// row of 7-segment displays, with its own step timing, direction and restart.
module deplasare_cerc_hex
    import deplasare_pkg::*;
#(
    parameter int   DISPLAY_COUNT = 6,
    parameter logic COMMON_ANODE  = 1'b1,
    parameter int   STEP_CYCLES   = 5_000_000,
    parameter int   TRAIL_MAX     = 4,
    parameter int   PERIM         = 2 * DISPLAY_COUNT + 4,
    parameter int   POS_W         = $clog2(PERIM),
    localparam int  TL_W          = $clog2(TRAIL_MAX + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          dir_i,
    input  logic                          restart_i,
    input  logic [TL_W-1:0]               trail_len_i,
    output logic [DISPLAY_COUNT-1:0][7:0] seg7_o,
    output logic [POS_W-1:0]              pos_o,
    output logic                          wrap_o
);

    localparam logic [POS_W-1:0] HEAD_LAST = POS_W'(PERIM - 1);
    localparam int LEN_MAX = (TRAIL_MAX < PERIM) ? TRAIL_MAX : PERIM;
    localparam logic [7:0] SEG_OFF = seg_off(COMMON_ANODE);

    logic                          tick;
    logic [POS_W-1:0]              head_q;
    logic [POS_W-1:0]              head_d;
    logic                          wrap_q;
    logic                          wrap_d;
    logic [DISPLAY_COUNT-1:0][7:0] lit;
    logic [DISPLAY_COUNT-1:0][7:0] seg_q;
    logic [DISPLAY_COUNT-1:0][7:0] seg_d;
    int                            len;
    int                            p;
    seg_loc_t                      loc;

    deplasare_prescaler #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .clear_i(restart_i),
        .tick_o (tick)
    );

    // Restart overrides a coincident tick and never reports a wrap.
    always_comb begin
        head_d = head_q;
        wrap_d = 1'b0;
        if (restart_i) begin
            head_d = '0;
        end else if (tick) begin
            if (dir_i) begin
                if (head_q == HEAD_LAST) begin
                    head_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    head_d = head_q + 1'b1;
                end
            end else begin
                if (head_q == '0) begin
                    head_d = HEAD_LAST;
                    wrap_d = 1'b1;
                end else begin
                    head_d = head_q - 1'b1;
                end
            end
        end
    end

    // Trail sits behind the direction of motion; len never exceeds PERIM,
    // so a single add/subtract of PERIM is enough to wrap.
    always_comb begin
        lit = '0;
        p   = 0;
        loc = '0;
        len = int'(trail_len_i);
        if (len < 1) len = 1;
        if (len > LEN_MAX) len = LEN_MAX;
        for (int j = 0; j < TRAIL_MAX; j++) begin
            if (j < len) begin
                p = dir_i ? int'(head_q) - j : int'(head_q) + j;
                if (p < 0) begin
                    p = p + PERIM;
                end else if (p >= PERIM) begin
                    p = p - PERIM;
                end
                loc = pos_to_seg(p, DISPLAY_COUNT);
                for (int d = 0; d < DISPLAY_COUNT; d++) begin
                    if (loc.disp == d) lit[d][loc.seg] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < DISPLAY_COUNT; d++) begin
            seg_d[d] = SEG_OFF ^ lit[d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            wrap_q <= 1'b0;
            for (int d = 0; d < DISPLAY_COUNT; d++) begin
                seg_q[d] <= SEG_OFF;
            end
        end else begin
            head_q <= head_d;
            wrap_q <= wrap_d;
            seg_q  <= seg_d;
        end
    end

    assign pos_o  = head_q;
    assign wrap_o = wrap_q;
    assign seg7_o = seg_q;

endmodule

// File: tb/tb_deplasare_cerc_hex.sv
// Directed bench for the perimeter animator: common-anode and common-cathode
// instances share the same stimulus.
module tb_deplasare_cerc_hex;

    logic             clk;
    logic             rst_ni;
    logic             en_i;
    logic             dir_i;
    logic             restart_i;
    logic [2:0]       trail_len_i;
    logic [5:0][7:0]  seg_ca;
    logic [5:0][7:0]  seg_ah;
    logic [3:0]       pos_ca;
    logic [3:0]       pos_ah;
    logic             wrap_ca;
    logic             wrap_ah;

    int checks   = 0;
    int failures = 0;

    deplasare_cerc_hex #(
        .DISPLAY_COUNT(6), .COMMON_ANODE(1'b1), .STEP_CYCLES(4), .TRAIL_MAX(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .dir_i(dir_i),
        .restart_i(restart_i), .trail_len_i(trail_len_i),
        .seg7_o(seg_ca), .pos_o(pos_ca), .wrap_o(wrap_ca)
    );

    deplasare_cerc_hex #(
        .DISPLAY_COUNT(6), .COMMON_ANODE(1'b0), .STEP_CYCLES(4), .TRAIL_MAX(4)
    ) dut_ah (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .dir_i(dir_i),
        .restart_i(restart_i), .trail_len_i(trail_len_i),
        .seg7_o(seg_ah), .pos_o(pos_ah), .wrap_o(wrap_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int lit_count(input logic [5:0][7:0] s);
        int c = 0;
        for (int d = 0; d < 6; d++)
            for (int b = 0; b < 8; b++)
                if (s[d][b] == 1'b0) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 1'b0; dir_i = 1'b1; restart_i = 1'b0; trail_len_i = 3'd1;
        step(3);
        checks++;
        if (pos_ca !== 4'd0) begin
            failures++; $display("FAIL reset_pos got=%0d want=0", pos_ca);
        end
        checks++;
        if (seg_ca !== {6{8'hFF}}) begin
            failures++; $display("FAIL reset_seg_ca got=%h want=%h", seg_ca, {6{8'hFF}});
        end
        checks++;
        if (seg_ah !== {6{8'h00}}) begin
            failures++; $display("FAIL reset_seg_ah got=%h want=%h", seg_ah, {6{8'h00}});
        end
        checks++;
        if (wrap_ca !== 1'b0) begin
            failures++; $display("FAIL reset_wrap got=%b want=0", wrap_ca);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        checks++;
        if (seg_ca !== {6{8'hFF}}) begin
            failures++; $display("FAIL release_first_cycle got=%h want=%h", seg_ca, {6{8'hFF}});
        end
        @(posedge clk);
        #1;
        checks++;
        if (seg_ca !== {8'hFE, {5{8'hFF}}}) begin
            failures++; $display("FAIL release_second_cycle got=%h want=%h", seg_ca, {8'hFE, {5{8'hFF}}});
        end
    endtask

    task automatic test_cw_lap();
        int wraps = 0;
        int exp_pos;
        en_i = 1'b1; dir_i = 1'b1; trail_len_i = 3'd1; restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            step(1);
            exp_pos = (c / 4) % 16;
            checks++;
            if (pos_ca !== 4'(exp_pos)) begin
                failures++; $display("FAIL lap_pos cycle=%0d got=%0d want=%0d", c, pos_ca, exp_pos);
            end
            if (wrap_ca) begin
                wraps++;
                checks++;
                if (c != 64) begin
                    failures++; $display("FAIL lap_wrap_when cycle=%0d got=1 want=0", c);
                end
            end
            if (c == 25) begin
                checks++;
                if (seg_ca[0] !== 8'hFD) begin
                    failures++; $display("FAIL lap_seg_b got=%h want=fd", seg_ca[0]);
                end
            end
            if (c == 33) begin
                checks++;
                if (seg_ca[0] !== 8'hF7) begin
                    failures++; $display("FAIL lap_seg_d got=%h want=f7", seg_ca[0]);
                end
            end
        end
        checks++;
        if (wraps != 1) begin
            failures++; $display("FAIL lap_wrap_count got=%0d want=1", wraps);
        end
    endtask

    task automatic test_ccw_trail();
        en_i = 1'b1; dir_i = 1'b1; trail_len_i = 3'd3; restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        step(4);
        checks++;
        if (pos_ca !== 4'd1) begin
            failures++; $display("FAIL ccw_setup_pos got=%0d want=1", pos_ca);
        end
        dir_i = 1'b0;
        step(4);
        checks++;
        if (pos_ca !== 4'd0) begin
            failures++; $display("FAIL ccw_pos got=%0d want=0", pos_ca);
        end
        step(1);
        checks++;
        if (seg_ca !== {8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF}) begin
            failures++; $display("FAIL ccw_trail_seg got=%h want=fefefeffffff", seg_ca);
        end
        step(3);
        checks++;
        if (pos_ca !== 4'd15 || wrap_ca !== 1'b1) begin
            failures++; $display("FAIL ccw_wrap pos=%0d wrap=%b want pos=15 wrap=1", pos_ca, wrap_ca);
        end
        step(1);
        checks++;
        if (seg_ca !== {8'hDE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF}) begin
            failures++; $display("FAIL ccw_seg_f got=%h want=defeffffffff", seg_ca);
        end
        checks++;
        if (wrap_ca !== 1'b0) begin
            failures++; $display("FAIL ccw_wrap_single got=%b want=0", wrap_ca);
        end
    endtask

    task automatic test_trail_clamp();
        en_i = 1'b0;
        trail_len_i = 3'd0;
        step(1);
        checks++;
        if (lit_count(seg_ca) != 1) begin
            failures++; $display("FAIL clamp_zero got=%0d want=1", lit_count(seg_ca));
        end
        trail_len_i = 3'd7;
        #1;
        checks++;
        if (lit_count(seg_ca) != 1) begin
            failures++; $display("FAIL clamp_latency got=%0d want=1", lit_count(seg_ca));
        end
        step(1);
        checks++;
        if (lit_count(seg_ca) != 4) begin
            failures++; $display("FAIL clamp_seven got=%0d want=4", lit_count(seg_ca));
        end
    endtask

    task automatic test_pause_restart();
        en_i = 1'b1; dir_i = 1'b1; trail_len_i = 3'd1; restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        step(2);
        en_i = 1'b0;
        step(10);
        checks++;
        if (pos_ca !== 4'd0) begin
            failures++; $display("FAIL pause_hold got=%0d want=0", pos_ca);
        end
        en_i = 1'b1;
        step(1);
        checks++;
        if (pos_ca !== 4'd0) begin
            failures++; $display("FAIL resume_early got=%0d want=0", pos_ca);
        end
        step(1);
        checks++;
        if (pos_ca !== 4'd1) begin
            failures++; $display("FAIL resume_step got=%0d want=1", pos_ca);
        end
        step(56);
        checks++;
        if (pos_ca !== 4'd15) begin
            failures++; $display("FAIL reach_15 got=%0d want=15", pos_ca);
        end
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        checks++;
        if (pos_ca !== 4'd0 || wrap_ca !== 1'b0) begin
            failures++; $display("FAIL restart_at_15 pos=%0d wrap=%b want pos=0 wrap=0", pos_ca, wrap_ca);
        end
        for (int c = 1; c <= 3; c++) begin
            step(1);
            checks++;
            if (pos_ca !== 4'd0 || wrap_ca !== 1'b0) begin
                failures++; $display("FAIL restart_hold cycle=%0d pos=%0d wrap=%b want pos=0 wrap=0", c, pos_ca, wrap_ca);
            end
        end
        step(1);
        checks++;
        if (pos_ca !== 4'd1) begin
            failures++; $display("FAIL restart_next_step got=%0d want=1", pos_ca);
        end
        en_i = 1'b0; restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        checks++;
        if (pos_ca !== 4'd0) begin
            failures++; $display("FAIL restart_disabled got=%0d want=0", pos_ca);
        end
    endtask

    task automatic test_active_high();
        en_i = 1'b1; dir_i = 1'b1; trail_len_i = 3'd1; restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        step(25);
        checks++;
        if (pos_ah !== 4'd6) begin
            failures++; $display("FAIL ah_pos got=%0d want=6", pos_ah);
        end
        checks++;
        if (seg_ah !== {{5{8'h00}}, 8'h02}) begin
            failures++; $display("FAIL ah_seg got=%h want=%h", seg_ah, {{5{8'h00}}, 8'h02});
        end
    endtask

    initial begin
        test_reset();
        test_cw_lap();
        test_ccw_trail();
        test_trail_clamp();
        test_pause_restart();
        test_active_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deplasare_cerc_hex.md
# deplasare_cerc_hex

Autonomous animator for a row of 7-segment displays. It moves one lit segment, or a trail of lit segments, around the outer perimeter of the whole display row, like a circle. It is the parametrised successor of the static single-segment shifter: it owns its own step timing, direction, pause, restart and trail length. It drives the on-board HEX bank directly. A higher-level controller supplies only the mode inputs.

## Interface
- `DISPLAY_COUNT`, default 6: number of displays, N ≥ 2. Display 0 is the rightmost.
- `COMMON_ANODE`, default 1'b1: 1 means segments are active-low, 0 means active-high.
- `STEP_CYCLES`, default 5_000_000: clock cycles per animation step, ≥ 2.
- `TRAIL_MAX`, default 4: maximum trail length, ≥ 1.
- `PERIM`, derived, 2·N+4: number of perimeter positions.
- `POS_W`, derived, $clog2(PERIM): width of the position counter.
- `clk_i`  in  1: single clock.
- `rst_ni`  in  1: reset, synchronous and active-low.
- `en_i`  in  1: 1 runs the animation, 0 freezes it (prescaler and position hold).
- `dir_i`  in  1: 1 is clockwise (position increments), 0 is counter-clockwise.
- `restart_i`  in  1: single-cycle pulse; returns the head to position 0 and clears the prescaler.
- `trail_len_i`  in  $clog2(TRAIL_MAX+1): number of lit segments. 0 is treated as 1. Values above TRAIL_MAX are clamped to TRAIL_MAX.
- `seg7_o`  out  [N-1:0][7:0]: registered segment outputs. Bit order is {dp,g,f,e,d,c,b,a}, with a = bit 0.
- `pos_o`  out  POS_W: current head position.
- `wrap_o`  out  1: one-cycle pulse when the head wraps.

## Operation
- **Perimeter map.**
  - Position k in 0..N-1: segment a of display N-1-k (top row, left to right).
  - N: segment b of display 0.
  - N+1: segment c of display 0.
  - N+2..2N+1: segment d of display k-N-2 (bottom row, right to left).
  - 2N+2: segment e of display N-1.
  - 2N+3: segment f of display N-1.
- **Prescaler.** The counter runs 0..STEP_CYCLES-1. The step tick is asserted when the counter equals STEP_CYCLES-1 and en_i=1; the counter then returns to 0.
- **Head update on a tick.**
  - dir_i=1: head = (head+1) mod PERIM.
  - dir_i=0: head = (head+PERIM-1) mod PERIM.
  - Modulo wrap is explicit. No power-of-2 assumption is allowed.
- **wrap_o.** Asserted in the cycle after a tick that moved the head from PERIM-1 to 0, or from 0 to PERIM-1.
- **Trail.** L = clamp(trail_len_i, 1, min(TRAIL_MAX, PERIM)).
  - Lit positions are head − j·s mod PERIM for j = 0..L-1, where s = +1 when dir_i=1 and −1 when dir_i=0. The trail always sits behind the direction of motion.
  - A change of dir_i or trail_len_i takes effect on the next seg7_o update, without waiting for a tick.
- **Output polarity.** dp and g are never lit. An unlit segment is 1 when COMMON_ANODE=1 and 0 otherwise. Lit segments are the inverse.
- **Priority.** !rst_ni > restart_i > tick.
- **restart_i.** Head goes to 0 and the prescaler to 0. No wrap_o is generated, even if the head was at PERIM-1.

## Timing
- **Reset values.**
  - Head = 0, prescaler = 0, pos_o = 0, wrap_o = 0.
  - seg7_o = all unlit (8'hFF per display when COMMON_ANODE=1, 8'h00 otherwise).
- **Head.** Updates at the clock edge ending the tick cycle. pos_o is the head register itself.
- **Segment latency.** seg7_o is registered from head, dir_i and trail_len_i, so it lags pos_o by exactly one cycle. In the first cycle after reset release, seg7_o still shows all unlit. From the second cycle it shows position 0.
- **Step period.** In steady state with en_i=1, the head moves every STEP_CYCLES cycles.
- **Pause.** Dropping en_i freezes the prescaler value. Resuming continues from that value; the prescaler is not cleared.
- **restart_i with en_i=0.** Restart still applies.
- **Reset mid-step.** Reset discards the partial prescaler count.

## Structure
- **Package `deplasare_pkg`** holds:
  - segment bit index constants SEG_A..SEG_DP;
  - function `seg_off(common_anode)`;
  - function `pos_to_seg(pos, n)`, returning {display index, segment index}.
- **Sub-module `deplasare_prescaler`**, parameter STEP_CYCLES: inputs clk_i, rst_ni, en_i and clear_i; output tick_o.
- **Top level** contains the head counter, wrap logic, the trail decode (a combinational loop over TRAIL_MAX) and the output register.

## Test plan
All scenarios use N=6 (PERIM=16), STEP_CYCLES=4, TRAIL_MAX=4 and COMMON_ANODE=1 unless stated.
1. **Reset.** Hold rst_ni=0 for 3 cycles, then release. Required:
   - pos_o=0 and seg7_o all 8'hFF during reset;
   - on the second cycle after release, seg7_o[5]=8'hFE (segment a of the leftmost display) and the other displays 8'hFF.
2. **Full clockwise lap.** en_i=1, dir_i=1, trail_len_i=1, run for 64 cycles. Required:
   - pos_o steps 0,1,…,15,0 every 4 cycles;
   - position 6 gives seg7_o[0]=8'hFD (segment b);
   - position 8 gives seg7_o[0]=8'hF7 (segment d);
   - wrap_o pulses exactly once, on the 15→0 step.
3. **Counter-clockwise with trail.** dir_i=0, trail_len_i=3, head at 1. Required:
   - next head position is 0;
   - lit positions are 0, 1 and 2, so seg7_o[5], [4] and [3] each equal 8'hFE;
   - stepping from 0 to 15 pulses wrap_o, and position 15 lights segment f of display 5.
4. **Trail clamping.** trail_len_i=0 lights exactly one segment. trail_len_i=7 lights exactly 4 segments. Both take effect one cycle after the input change.
5. **Pause and restart.** Required:
   - deassert en_i for 10 cycles mid-count: pos_o stays constant, and after resuming the next step arrives after the remaining prescaler cycles only;
   - pulse restart_i at pos_o=15: pos_o becomes 0 with no wrap_o, and the next step comes 4 cycles later.
6. **Active-high build.** COMMON_ANODE=0, head at 6. Required: seg7_o[0]=8'h02, and every other display 8'h00.
